// File: rtl/game_state_keeper_if.sv
// game_state_keeper_if
// Command/state bus between game_controller (master) and game_state_keeper
// (slave).
//   game_state_en, sel        : command strobe and opcode (00 load, 01 commit,
//                               10 retract, 11 no-op)
//   level_state, next_state   : 134-bit candidate states {way, box, man}
//   game_state                : live registered board state
//   history_count/can_retract : undo history occupancy
//   step_count                : moves on the current level, net of retracts
//   retract_fail              : one-cycle pulse for a retract on empty history
interface game_state_keeper_if #(
  parameter int PTR_W  = 3,
  parameter int STEP_W = 10
);
  logic               game_state_en;
  logic [1:0]         sel;
  logic [133:0]       level_state;
  logic [133:0]       next_state;
  logic [133:0]       game_state;
  logic [PTR_W:0]     history_count;
  logic               can_retract;
  logic [STEP_W-1:0]  step_count;
  logic               retract_fail;

  modport master (
    output game_state_en, sel, level_state, next_state,
    input  game_state, history_count, can_retract, step_count, retract_fail
  );

  modport slave (
    input  game_state_en, sel, level_state, next_state,
    output game_state, history_count, can_retract, step_count, retract_fail
  );
endinterface

// File: rtl/game_state_keeper.sv
// game_state_keeper
// Holds the live Sokoban board state plus a circular undo history of DEPTH
// entries. Load replaces the state and clears the history, commit pushes the
// old state and takes next_state, retract pops the newest entry.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : game_state_keeper_if slave modport (commands in, state out)
module game_state_keeper #(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3,
  parameter int STEP_W = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  game_state_keeper_if.slave   bus
);

  localparam logic [PTR_W:0]    CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [STEP_W-1:0] STEP_MAX = '1;

  logic [133:0]      r_gs;
  logic [PTR_W:0]    r_cnt;
  logic              r_can;
  logic [STEP_W-1:0] r_step;
  logic              r_fail;
  logic [PTR_W-1:0]  r_wp;
  logic [133:0]      r_hist [DEPTH];

  logic [133:0]      w_gs_nxt;
  logic [PTR_W:0]    w_cnt_nxt;
  logic [STEP_W-1:0] w_step_nxt;
  logic              w_fail_nxt;
  logic [PTR_W-1:0]  w_wp_nxt;
  logic              w_wr_en;
  logic [PTR_W-1:0]  w_rd_addr;

  // Newest history entry sits just below the write pointer (wraps mod DEPTH).
  assign w_rd_addr = r_wp - PTR_W'(1);

  // Next-state decode of the command; everything holds unless a command says otherwise.
  always_comb begin
    w_gs_nxt   = r_gs;
    w_cnt_nxt  = r_cnt;
    w_step_nxt = r_step;
    w_wp_nxt   = r_wp;
    w_fail_nxt = 1'b0;
    w_wr_en    = 1'b0;
    if (bus.game_state_en) begin
      case (bus.sel)
        2'b00: begin
          // Pointer is left alone; a zero count makes old entries unreachable.
          w_gs_nxt   = bus.level_state;
          w_cnt_nxt  = '0;
          w_step_nxt = '0;
        end
        2'b01: begin
          w_wr_en  = 1'b1;
          w_wp_nxt = r_wp + PTR_W'(1);
          w_gs_nxt = bus.next_state;
          // When full the oldest slot is overwritten, so the count stays at DEPTH.
          if (r_cnt != CNT_FULL) begin
            w_cnt_nxt = r_cnt + (PTR_W+1)'(1);
          end else begin
            w_cnt_nxt = r_cnt;
          end
          if (r_step != STEP_MAX) begin
            w_step_nxt = r_step + STEP_W'(1);
          end else begin
            w_step_nxt = r_step;
          end
        end
        2'b10: begin
          if (r_cnt != '0) begin
            w_wp_nxt  = w_rd_addr;
            w_gs_nxt  = r_hist[w_rd_addr];
            w_cnt_nxt = r_cnt - (PTR_W+1)'(1);
            if (r_step != '0) begin
              w_step_nxt = r_step - STEP_W'(1);
            end else begin
              w_step_nxt = r_step;
            end
          end else begin
            w_fail_nxt = 1'b1;
          end
        end
        default: begin
          w_fail_nxt = 1'b0;
        end
      endcase
    end else begin
      w_fail_nxt = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gs   <= '0;
      r_cnt  <= '0;
      r_can  <= 1'b0;
      r_step <= '0;
      r_fail <= 1'b0;
      r_wp   <= '0;
    end else begin
      r_gs   <= w_gs_nxt;
      r_cnt  <= w_cnt_nxt;
      r_can  <= (w_cnt_nxt != '0);
      r_step <= w_step_nxt;
      r_fail <= w_fail_nxt;
      r_wp   <= w_wp_nxt;
    end
  end

  // History RAM write port; contents need no reset because the count gates reads.
  always_ff @(posedge clk) begin
    if (!reset && w_wr_en) begin
      r_hist[r_wp] <= r_gs;
    end
  end

  assign bus.game_state    = r_gs;
  assign bus.history_count = r_cnt;
  assign bus.can_retract   = r_can;
  assign bus.step_count    = r_step;
  assign bus.retract_fail  = r_fail;

endmodule

// File: tb/tb_game_state_keeper.sv
module tb_game_state_keeper;

  typedef struct packed {
    logic [133:0] gs;
    logic [3:0]   cnt;
    logic         can;
    logic [9:0]   step;
    logic         fail;
  } exp_t;

  localparam logic [133:0] LVL  = {64'h0, 64'h1, 6'd0};
  localparam logic [133:0] LVL2 = {64'h0000_0000_0000_00FF, 64'h2, 6'd5};

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  exp_t  exp_q [$];
  string name_q [$];

  game_state_keeper_if #(.PTR_W(3), .STEP_W(10)) bus ();

  game_state_keeper #(.DEPTH(8), .PTR_W(3), .STEP_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct full-width state whose man field is m.
  function automatic logic [133:0] mk(input int m);
    logic [63:0] way;
    logic [63:0] box;
    logic [5:0]  man;
    way = 64'hA5A5_0000_0000_0000 | 64'(m);
    box = 64'h1 << m;
    man = 6'(m);
    return {way, box, man};
  endfunction

  // State whose man field is m, where man=0 is the loaded level image.
  function automatic logic [133:0] st(input int m);
    if (m == 0) return LVL;
    return mk(m);
  endfunction

  function automatic exp_t ex(input logic [133:0] gs, input int cnt, input int step, input logic fail);
    exp_t e;
    e.gs   = gs;
    e.cnt  = 4'(cnt);
    e.can  = (cnt != 0);
    e.step = 10'(step);
    e.fail = fail;
    return e;
  endfunction

  task automatic check(input string nm, input logic [133:0] act, input logic [133:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Issue one command across one rising edge and queue what must appear after it.
  task automatic cmd(input logic rst, input logic en, input logic [1:0] s,
                     input logic [133:0] lv, input logic [133:0] nx,
                     input exp_t e, input string nm);
    reset              = rst;
    bus.game_state_en  = en;
    bus.sel            = s;
    bus.level_state    = lv;
    bus.next_state     = nx;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    reset             = 1'b0;
    bus.game_state_en = 1'b0;
    bus.sel           = 2'b11;
  endtask

  // Monitor: compares the DUT against the scoreboard away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check({n, ".game_state"},    bus.game_state,             e.gs);
      check({n, ".history_count"}, 134'(bus.history_count),    134'(e.cnt));
      check({n, ".can_retract"},   134'(bus.can_retract),      134'(e.can));
      check({n, ".step_count"},    134'(bus.step_count),       134'(e.step));
      check({n, ".retract_fail"},  134'(bus.retract_fail),     134'(e.fail));
    end
  end

  initial begin
    tests_run         = 0;
    tests_failed      = 0;
    reset             = 1'b1;
    bus.game_state_en = 1'b0;
    bus.sel           = 2'b11;
    bus.level_state   = '0;
    bus.next_state    = '0;

    cmd(1'b1, 1'b0, 2'b11, LVL, mk(7), ex('0, 0, 0, 1'b0), "reset0");
    cmd(1'b1, 1'b0, 2'b11, LVL, mk(7), ex('0, 0, 0, 1'b0), "reset1");

    // Load level image.
    cmd(1'b0, 1'b1, 2'b00, LVL, mk(7), ex(134'h40, 0, 0, 1'b0), "load");

    // Three commits then three retracts.
    for (int i = 1; i <= 3; i++)
      cmd(1'b0, 1'b1, 2'b01, LVL2, mk(i), ex(mk(i), i, i, 1'b0), "commit3");
    for (int i = 2; i >= 0; i--)
      cmd(1'b0, 1'b1, 2'b10, LVL2, mk(9), ex(st(i), i, i, 1'b0), "retract3");

    // Retract on empty history pulses fail for one cycle only.
    cmd(1'b0, 1'b1, 2'b10, LVL2, mk(9), ex(LVL, 0, 0, 1'b1), "retract_empty");
    cmd(1'b0, 1'b0, 2'b11, LVL2, mk(9), ex(LVL, 0, 0, 1'b0), "fail_drop");

    // Ten commits saturate the history at 8.
    for (int i = 1; i <= 10; i++)
      cmd(1'b0, 1'b1, 2'b01, LVL2, mk(i), ex(mk(i), (i > 8) ? 8 : i, i, 1'b0), "commit10");
    for (int k = 1; k <= 8; k++)
      cmd(1'b0, 1'b1, 2'b10, LVL2, mk(9), ex(mk(10 - k), 8 - k, 10 - k, 1'b0), "retract8");
    cmd(1'b0, 1'b1, 2'b10, LVL2, mk(9), ex(mk(2), 0, 2, 1'b1), "retract9");

    // Disabled strobe and no-op opcode hold everything.
    cmd(1'b0, 1'b0, 2'b01, LVL2, mk(30), ex(mk(2), 0, 2, 1'b0), "en_low");
    cmd(1'b0, 1'b1, 2'b11, LVL2, mk(30), ex(mk(2), 0, 2, 1'b0), "nop");
    cmd(1'b0, 1'b1, 2'b01, LVL2, mk(31), ex(mk(31), 1, 3, 1'b0), "commit_pre_rst");
    cmd(1'b1, 1'b1, 2'b01, LVL2, mk(32), ex('0, 0, 0, 1'b0), "reset_commit");

    // Two commits then retry load; following retract must fail.
    cmd(1'b0, 1'b1, 2'b00, LVL, mk(9), ex(LVL, 0, 0, 1'b0), "reload");
    cmd(1'b0, 1'b1, 2'b01, LVL2, mk(1), ex(mk(1), 1, 1, 1'b0), "retry_c1");
    cmd(1'b0, 1'b1, 2'b01, LVL2, mk(2), ex(mk(2), 2, 2, 1'b0), "retry_c2");
    cmd(1'b0, 1'b1, 2'b00, LVL2, mk(9), ex(LVL2, 0, 0, 1'b0), "retry_load");
    cmd(1'b0, 1'b1, 2'b10, LVL, mk(9), ex(LVL2, 0, 0, 1'b1), "retry_retract");
    cmd(1'b0, 1'b0, 2'b11, LVL, mk(9), ex(LVL2, 0, 0, 1'b0), "final_idle");

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 134'(exp_q.size()), 134'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
